// File: rtl/inst_decode_queue.sv
// inst_decode_queue: decodes instruction words as they are accepted from
// fetch and buffers the decoded fields in a DEPTH-entry FIFO. The control
// unit reads the head entry through a valid/ready handshake.
module inst_decode_queue #(
   parameter  int DEPTH  = 2,
   parameter  int INST_W = 32,
   parameter  int OP_W   = 6,
   parameter  int REG_W  = 4,
   localparam int IMM_W  = INST_W - OP_W - 2*REG_W - 2,
   localparam int F_W    = INST_W - OP_W,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OP_W-1:0]   op_code,
   output logic [2:0]        inst_class,
   output logic [REG_W-1:0]  inst_rd,
   output logic [REG_W-1:0]  inst_rs1,
   output logic [REG_W-1:0]  inst_rs2,
   output logic [IMM_W-1:0]  imm,
   output logic [INST_W-1:0] imm_sext,
   output logic [1:0]        mode,
   output logic [F_W-1:0]    jump_offset,
   output logic [CNT_W-1:0]  count
);

   typedef enum logic [2:0] {
      CL_R   = 3'd0,
      CL_I   = 3'd1,
      CL_J   = 3'd2,
      CL_S   = 3'd3,
      CL_RET = 3'd4,
      CL_ILL = 3'd7
   } class_e;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      class_e           cls;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [IMM_W-1:0] imm;
      logic [1:0]       mode;
      logic [F_W-1:0]   joff;
   } entry_t;

   entry_t             mem [DEPTH];
   entry_t             dec;
   entry_t             head;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [OP_W-1:0]    opc;
   logic               push;
   logic               pop;

   assign opc       = inst[INST_W-1 -: OP_W];
   assign in_ready  = (count < CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Decode the incoming word; fields unused by its class stay zero.
   // NOTE: every output of a combinational block gets a default first, so
   // no path through the if/else leaves a value held and no latch is inferred.
   always_comb begin
      dec     = '0;
      dec.op  = opc;
      dec.cls = CL_ILL;
      if (opc <= OP_W'(2)) begin
         dec.cls = CL_R;
         dec.rd  = inst[F_W-1 -: REG_W];
         dec.rs1 = inst[F_W-REG_W-1 -: REG_W];
         dec.rs2 = inst[F_W-2*REG_W-1 -: REG_W];
      end else if (opc <= OP_W'(11)) begin
         dec.cls  = CL_I;
         dec.rd   = inst[F_W-1 -: REG_W];
         dec.rs1  = inst[F_W-REG_W-1 -: REG_W];
         dec.imm  = inst[IMM_W+1:2];
         dec.mode = inst[1:0];
      end else if (opc <= OP_W'(13)) begin
         dec.cls  = CL_J;
         dec.joff = inst[F_W-1:0];
      end else if (opc == OP_W'(14)) begin
         dec.cls = CL_RET;
      end else if (opc <= OP_W'(16)) begin
         dec.cls = CL_S;
         dec.rd  = inst[F_W-1 -: REG_W];
      end
   end

   // Pointer and occupancy tracking; flush outranks push and pop.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Entry storage written with the decoded fields of each accepted word.
   // NOTE: the array is deliberately not reset; nothing reads an entry
   // before it is written because outputs are gated by out_valid.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= dec;
   end

   assign head = mem[rd_ptr];

   // Head-entry read mux; all fields read as zero while the queue is empty.
   always_comb begin
      op_code     = '0;
      inst_class  = '0;
      inst_rd     = '0;
      inst_rs1    = '0;
      inst_rs2    = '0;
      imm         = '0;
      mode        = '0;
      jump_offset = '0;
      if (out_valid) begin
         op_code     = head.op;
         inst_class  = head.cls;
         inst_rd     = head.rd;
         inst_rs1    = head.rs1;
         inst_rs2    = head.rs2;
         imm         = head.imm;
         mode        = head.mode;
         jump_offset = head.joff;
      end
   end

   assign imm_sext = {{(INST_W-IMM_W){imm[IMM_W-1]}}, imm};

endmodule

// File: tb/tb_inst_decode_queue.sv
// Directed bench for inst_decode_queue with a decoded-entry scoreboard.
module tb_inst_decode_queue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [5:0]  op;
      logic [2:0]  cls;
      logic [3:0]  rd, rs1, rs2;
      logic [15:0] imm;
      logic [1:0]  mode;
      logic [25:0] joff;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] inst = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [5:0]  op_code;
   logic [2:0]  inst_class;
   logic [3:0]  inst_rd, inst_rs1, inst_rs2;
   logic [15:0] imm;
   logic [31:0] imm_sext;
   logic [1:0]  mode;
   logic [25:0] jump_offset;
   logic [2:0]  count;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   inst_decode_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
      .out_valid(out_valid), .out_ready(out_ready),
      .op_code(op_code), .inst_class(inst_class),
      .inst_rd(inst_rd), .inst_rs1(inst_rs1), .inst_rs2(inst_rs2),
      .imm(imm), .imm_sext(imm_sext), .mode(mode),
      .jump_offset(jump_offset), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Reference decode written from the instruction format at default widths.
   function automatic exp_t model(input logic [31:0] w);
      exp_t e;
      e = '{op: w[31:26], cls: 3'd7, rd: 4'd0, rs1: 4'd0, rs2: 4'd0,
            imm: 16'd0, mode: 2'd0, joff: 26'd0};
      if (e.op <= 6'd2) begin
         e.cls = 3'd0; e.rd = w[25:22]; e.rs1 = w[21:18]; e.rs2 = w[17:14];
      end else if (e.op <= 6'd11) begin
         e.cls = 3'd1; e.rd = w[25:22]; e.rs1 = w[21:18];
         e.imm = w[17:2]; e.mode = w[1:0];
      end else if (e.op == 6'd12 || e.op == 6'd13) begin
         e.cls = 3'd2; e.joff = w[25:0];
      end else if (e.op == 6'd14) begin
         e.cls = 3'd4;
      end else if (e.op == 6'd15 || e.op == 6'd16) begin
         e.cls = 3'd3; e.rd = w[25:22];
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_head(input string tag, input exp_t e);
      check({tag, "_op"},   op_code,     e.op);
      check({tag, "_cls"},  inst_class,  e.cls);
      check({tag, "_rd"},   inst_rd,     e.rd);
      check({tag, "_rs1"},  inst_rs1,    e.rs1);
      check({tag, "_rs2"},  inst_rs2,    e.rs2);
      check({tag, "_imm"},  imm,         e.imm);
      check({tag, "_sext"}, imm_sext,    {{16{e.imm[15]}}, e.imm});
      check({tag, "_mode"}, mode,        e.mode);
      check({tag, "_joff"}, jump_offset, e.joff);
   endtask

   task automatic check_idle(input string tag);
      exp_t z;
      z = '{op: 6'd0, cls: 3'd0, rd: 4'd0, rs1: 4'd0, rs2: 4'd0,
            imm: 16'd0, mode: 2'd0, joff: 26'd0};
      check({tag, "_count"}, count, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_in_ready"}, in_ready, 1);
      check_head(tag, z);
   endtask

   // One clock with the currently driven inputs; the scoreboard is updated
   // from the bench's own occupancy, then the DUT state is compared.
   task automatic cycle(input string tag);
      bit   do_push, do_pop;
      exp_t d;
      do_push = in_valid && (sb.size() < DEPTH) && !flush;
      do_pop  = (sb.size() != 0) && out_ready && !flush;
      if (do_pop) d = sb.pop_front();
      if (flush) sb.delete();
      if (do_push) sb.push_back(model(inst));
      @(posedge clk); #1;
      check({tag, "_count"}, count, sb.size());
      check({tag, "_out_valid"}, out_valid, sb.size() != 0);
      check({tag, "_in_ready"}, in_ready, sb.size() < DEPTH);
      if (sb.size() != 0) check_head({tag, "_head"}, sb[0]);
      else check_idle({tag, "_idle"});
   endtask

   function automatic logic [31:0] rand_word();
      return {6'($urandom_range(0, 63)), 26'($urandom)};
   endfunction

   initial begin
      // Reset state
      #3;
      check_idle("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      // ADD then a decode walk with simultaneous push/pop at count=1
      in_valid = 1'b1; inst = 32'h0094C000;
      cycle("add");
      check("add_class", inst_class, 0);
      check("add_rd", inst_rd, 2);
      check("add_rs1", inst_rs1, 5);
      check("add_rs2", inst_rs2, 3);
      check("add_imm", imm, 0);
      check("add_mode", mode, 0);

      out_ready = 1'b1; inst = 32'h0C020006;  // op=3 imm=0x8001 mode=2
      cycle("itype");
      check("i_count", count, 1);
      check("i_class", inst_class, 1);
      check("i_sext", imm_sext, 32'hFFFF8001);
      check("i_rs2", inst_rs2, 0);
      check("i_mode", mode, 2);

      inst = 32'h33FFFFFF;                   // op=12 offset 0x3FFFFFF
      cycle("jtype");
      check("j_class", inst_class, 2);
      check("j_off", jump_offset, 26'h3FFFFFF);

      inst = 32'h38123456;                   // op=14, junk field bits
      cycle("ret");
      check("ret_class", inst_class, 4);
      check("ret_off", jump_offset, 0);
      check("ret_rd", inst_rd, 0);

      inst = 32'hFC654321;                   // op=0x3F
      cycle("ill");
      check("ill_class", inst_class, 7);
      check("ill_op", op_code, 6'h3F);
      check("ill_off", jump_offset, 0);

      in_valid = 1'b0;
      cycle("drain1");

      // Fill to DEPTH without consuming, then offer one more word
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         inst = rand_word();
         cycle("fill");
      end
      check("full_in_ready", in_ready, 0);
      check("full_count", count, DEPTH);
      inst = 32'h00400000;
      cycle("full_ignore");
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) cycle("popall");
      check("empty_count", count, 0);

      // Streaming at count=1 across several pointer wraps
      in_valid = 1'b1; out_ready = 1'b0; inst = rand_word();
      cycle("prime");
      out_ready = 1'b1;
      for (int i = 0; i < 3*DEPTH; i++) begin
         inst = rand_word();
         cycle("stream");
      end
      in_valid = 1'b0;
      cycle("drain2");

      // Flush while full with a word presented
      in_valid = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         inst = rand_word();
         cycle("prefl");
      end
      out_ready = 1'b1; flush = 1'b1; inst = 32'h04400000;
      cycle("flush");
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

      // Reset asserted between edges mid-stream
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         inst = rand_word();
         cycle("prerst");
      end
      #3;
      reset = 1'b1;
      #1;
      sb.delete();
      check_idle("async_rst");
      @(posedge clk); #1;
      check_idle("rst_held");
      reset = 1'b0; inst = 32'h3C800000;     // op=15 (S) rd=2
      cycle("post_rst");
      check("post_rst_class", inst_class, 3);
      in_valid = 1'b0; out_ready = 1'b1;
      cycle("final_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
